// File: rtl/aes128_core_arbiter.sv
// Two-requester round-robin front end for a single AES-128 encryption core.
// One job in flight at a time; a core that never reports done is cut off after TIMEOUT cycles.
module aes128_core_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         req0_valid_i,
  input  logic [127:0] req0_key_i,
  input  logic [127:0] req0_data_i,
  output logic         req0_ready_o,
  input  logic         req1_valid_i,
  input  logic [127:0] req1_key_i,
  input  logic [127:0] req1_data_i,
  output logic         req1_ready_o,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic         res_id_o,
  output logic [127:0] res_data_o,
  output logic         res_err_o,
  output logic         core_start_o,
  output logic [127:0] core_key_o,
  output logic [127:0] core_data_o,
  input  logic [127:0] core_data_i,
  input  logic         core_done_i,
  output logic         busy_o
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_MAX  = {TW{1'b1}};
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [TW-1:0]  timer_r;
  logic           last_grant_r;
  logic [127:0]   key_r;
  logic [127:0]   data_r;
  logic           res_id_r;
  logic [127:0]   res_data_r;
  logic           res_err_r;
  logic           accept_s;
  logic           grant_s;
  logic           timeout_s;

  // Grant selection and next-state decode.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    grant_s   = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0_valid_i && req1_valid_i) begin
          accept_s = 1'b1;
          grant_s  = ~last_grant_r;
        end else if (req0_valid_i) begin
          accept_s = 1'b1;
          grant_s  = 1'b0;
        end else if (req1_valid_i) begin
          accept_s = 1'b1;
          grant_s  = 1'b1;
        end else begin
          accept_s = 1'b0;
          grant_s  = 1'b0;
        end
        if (accept_s) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: state_s = WAIT;
      WAIT: begin
        // done takes priority over a timeout landing in the same cycle
        timeout_s = (timer_r >= TMR_LAST);
        if (core_done_i || timeout_s) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (res_ready_i) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, capture, timer and result registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= IDLE;
      timer_r      <= {TW{1'b0}};
      last_grant_r <= 1'b1;
      key_r        <= 128'h0;
      data_r       <= 128'h0;
      res_id_r     <= 1'b0;
      res_data_r   <= 128'h0;
      res_err_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            key_r    <= grant_s ? req1_key_i  : req0_key_i;
            data_r   <= grant_s ? req1_data_i : req0_data_i;
            res_id_r <= grant_s;
          end
        end
        START: timer_r <= {TW{1'b0}};
        WAIT: begin
          if (core_done_i) begin
            res_data_r <= core_data_i;
            res_err_r  <= 1'b0;
          end else if (timeout_s) begin
            res_data_r <= 128'h0;
            res_err_r  <= 1'b1;
          end else if (timer_r != TMR_MAX) begin
            timer_r <= timer_r + TMR_ONE;
          end
        end
        RESP: begin
          if (res_ready_i) begin
            last_grant_r <= res_id_r;
          end
        end
        default: ;
      endcase
    end
  end

  // Ready is combinational so the requester sees acceptance in the cycle it asks.
  assign req0_ready_o = accept_s && !grant_s && !reset_i;
  assign req1_ready_o = accept_s &&  grant_s && !reset_i;

  assign core_start_o = (state_r == START);
  assign res_valid_o  = (state_r == RESP);
  assign busy_o       = (state_r != IDLE);
  assign core_key_o   = key_r;
  assign core_data_o  = data_r;
  assign res_id_o     = res_id_r;
  assign res_data_o   = res_data_r;
  assign res_err_o    = res_err_r;

endmodule

// File: doc/aes128_core_arbiter.md
AES128_CORE_ARBITER -- requirements
Module: aes128_core_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 64, maximum number of WAIT cycles allowed for core_done_i before the block aborts the job.
REQ-002 The block SHALL have one clock, clk_i; reset is synchronous and active-high, reset_i.
REQ-003 Ports SHALL be as follows (N = 0 or 1):
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- reqN_valid_i  in  1  requester N has a block pending.
- reqN_key_i  in  128  requester N AES-128 key.
- reqN_data_i  in  128  requester N plaintext.
- reqN_ready_o  out  1  requester N job accepted this cycle.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  result consumer accepts the result.
- res_id_o  out  1  requester index owning the result.
- res_data_o  out  128  ciphertext, or 0 on timeout.
- res_err_o  out  1  timeout flag for this result.
- core_start_o  out  1  one-cycle start pulse to the encryption core.
- core_key_o  out  128  key to the core.
- core_data_o  out  128  plaintext to the core.
- core_data_i  in  128  ciphertext from the core.
- core_done_i  in  1  core completion strobe.
- busy_o  out  1  high whenever the block is not in IDLE.

Function
REQ-004 The block SHALL implement an FSM with states IDLE, START, WAIT and RESP, and exactly one job in flight at a time.
REQ-005 IDLE, grant rule:
- If only one reqN_valid_i is high, that requester SHALL be granted.
- If both are high, the requester not equal to last_grant SHALL be granted (round-robin).
REQ-006 IDLE, accept cycle:
- The granted reqN_ready_o SHALL be driven high combinationally in the same cycle; the other ready SHALL be low.
- The block SHALL capture the granted key and data into internal registers, record the grant index, and move to START.
REQ-007 reqN_ready_o SHALL be low in every state other than IDLE.
REQ-008 START SHALL last exactly one cycle with core_start_o=1, clear the timer, and then move to WAIT.
REQ-009 core_key_o and core_data_o SHALL equal the captured registers and SHALL hold stable from START until the block leaves RESP.
REQ-010 WAIT, completion: on core_done_i=1 the block SHALL register core_data_i into res_data_o, set res_err_o=0, and move to RESP.
REQ-011 WAIT, timeout: the timer SHALL increment each cycle without done. When it reaches TIMEOUT-1 without done, the block SHALL set res_data_o=0 and res_err_o=1 and move to RESP.
REQ-012 If core_done_i and the timeout occur in the same cycle, done SHALL win.
REQ-013 core_done_i SHALL be ignored in IDLE, START and RESP.
REQ-014 RESP:
- res_valid_o SHALL be 1, with res_id_o, res_data_o and res_err_o held stable until res_ready_i=1.
- On the handshake cycle, last_grant SHALL be set to res_id_o and the FSM SHALL return to IDLE.
REQ-015 res_valid_o SHALL be 1 only in RESP.
REQ-016 Latency: an accept in cycle T SHALL give core_start_o in cycle T+1. A done sampled in cycle D SHALL give res_valid_o in cycle D+1.
REQ-017 Back-to-back: after a result handshake in cycle M, a new accept is possible in cycle M+1.
REQ-018 The timer SHALL be $clog2(TIMEOUT)+1 bits wide and SHALL saturate without wrapping.
REQ-019 busy_o SHALL be 1 in START, WAIT and RESP, and 0 in IDLE.

Reset
REQ-020 When reset_i=1 at a clock edge, the following SHALL take effect at that edge and override all other activity, including mid-job:
- FSM to IDLE, timer=0, last_grant=1 (so req0 wins the first tie).
- All captured registers, res_data_o, res_id_o and res_err_o to 0.
- core_start_o, res_valid_o, reqN_ready_o and busy_o to 0.
REQ-021 A job in flight during reset SHALL be discarded with no result emitted; a core_done_i arriving later SHALL be ignored.

Verification
REQ-022 Single request: req0 valid with FIPS-197 key 000102..0f and plaintext 00112233..ff; core model returns 69c4e0d8..c55a after 10 cycles.
-> req0_ready_o pulses once; core_start_o pulses the next cycle; RESP gives res_id_o=0, res_data_o=69c4e0d8..c55a, res_err_o=0.
REQ-023 Tie after reset: both requests valid continuously for two jobs.
-> Grants go req0 then req1; res_id_o sequence is 0, 1.
REQ-024 Timeout: TIMEOUT=8 and core_done_i never asserts.
-> 8 WAIT cycles, then RESP with res_data_o=0, res_err_o=1; the FSM returns to IDLE after res_ready_i.
REQ-025 Backpressure: res_ready_i held low for 20 cycles.
-> res_valid_o and res_data_o stay stable; reqN_ready_o stays 0 throughout.
REQ-026 Reset mid-WAIT, then core_done_i arrives two cycles later.
-> busy_o=0 and res_valid_o never asserts; the next req1 is accepted normally.
REQ-027 Done and timeout in the same cycle.
-> res_err_o=0 and res_data_o equals core_data_i.
